// File: rtl/pr_mem_arbiter.sv
// Round-robin arbiter sharing the pageRank accelerator's single memory port
// among eight requesters; one transaction outstanding at a time.
module pr_mem_arbiter #(
    parameter int abits = 32,
    parameter int dbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         req_val,
    output logic [7:0]         req_rdy,
    input  logic [8*abits-1:0] req_addr,
    input  logic [7:0]         req_wen,
    input  logic [8*dbits-1:0] req_wdata,
    output logic               mem_req_val,
    input  logic               mem_req_rdy,
    output logic [abits-1:0]   mem_req_addr,
    output logic               mem_req_wen,
    output logic [dbits-1:0]   mem_req_wdata,
    input  logic               mem_resp_val,
    input  logic [dbits-1:0]   mem_resp_data,
    output logic [7:0]         resp_val,
    output logic [dbits-1:0]   resp_data,
    output logic [2:0]         grant_sel,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         ptr, gnt;
    logic [abits-1:0]   addr_q;
    logic               wen_q;
    logic [dbits-1:0]   wdata_q;

    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         scan_idx;

    // Rotating priority scan: first requester found starting at ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = ptr;
        scan_idx  = ptr;
        for (int k = 0; k < 8; k++) begin
            scan_idx = ptr + 3'(k);
            if (!win_found && req_val[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_rdy     = '0;
        mem_req_val = 1'b0;
        resp_val    = '0;
        unique case (state)
            S_IDLE: begin
                if (win_found) begin
                    req_rdy[win_idx] = 1'b1;
                    state_nxt        = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_val = 1'b1;
                if (mem_req_rdy) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_val) begin
                    resp_val[gnt] = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            gnt     <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all registered state avoid ordering races.
            state <= state_nxt;
            if (state == S_IDLE && win_found) begin
                gnt     <= win_idx;
                addr_q  <= req_addr[win_idx*abits +: abits];
                wen_q   <= req_wen[win_idx];
                wdata_q <= req_wdata[win_idx*dbits +: dbits];
            end
            // Priority moves past the winner only once its response is delivered.
            if (state == S_WAIT && mem_resp_val) begin
                ptr <= gnt + 3'd1;
            end
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign resp_data     = mem_resp_data;
    assign grant_sel     = gnt;
    assign busy          = (state != S_IDLE);

endmodule

// File: doc/pr_mem_arbiter.md
# pr_mem_arbiter

Round-robin arbiter that shares the single memory port of the pageRank accelerator among up to eight requesters: rank-read, rank-write, edge-fetch and similar engines. It accepts one request at a time, forwards it to memory, and routes the response back to the requester that won. It also drives the 3-bit select consumed by the accelerator's 8:1 mux on the shared data path. Only one transaction is ever outstanding.

## Interface
Parameters:
- abits, 32, address width
- dbits, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_val  in  8  per-requester request valid
- req_rdy  out  8  per-requester accept, one-hot or zero
- req_addr  in  8*abits  packed addresses; requester i at bits [i*abits +: abits]
- req_wen  in  8  per-requester write enable (1 = write, 0 = read)
- req_wdata  in  8*dbits  packed write data; requester i at bits [i*dbits +: dbits]
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  abits  latched address
- mem_req_wen  out  1  latched write enable
- mem_req_wdata  out  dbits  latched write data
- mem_resp_val  in  1  memory response valid; reads and writes both get one
- mem_resp_data  in  dbits  read data; don't-care for writes
- resp_val  out  8  one-hot response strobe to the granted requester
- resp_data  out  dbits  equals mem_resp_data, combinational pass-through
- grant_sel  out  3  index of the current or last grant; drives the shared mux select
- busy  out  1  high in REQ or WAIT

## Operation
- State: FSM {IDLE, REQ, WAIT}, 3-bit priority pointer ptr, 3-bit grant register gnt, and latched addr/wen/wdata.
- IDLE, no request: if req_val is all zeros, stay in IDLE and keep req_rdy = 0.
- IDLE, request pending: winner = first i with req_val[i] set, scanning ptr, ptr+1, …, ptr+7 mod 8.
  - req_rdy[winner] = 1 combinationally in this cycle.
  - On the clock edge: gnt <= winner; latch that requester's addr, wen and wdata; go to REQ.
- REQ:
  - mem_req_val = 1, driven with the latched fields.
  - When mem_req_rdy = 1, go to WAIT; otherwise hold and keep all fields stable.
- WAIT:
  - When mem_resp_val = 1: resp_val[gnt] = 1 for that cycle only, resp_data = mem_resp_data, ptr <= gnt + 1 (wraps 7 -> 0), go to IDLE.
- grant_sel = gnt at all times. Its value in IDLE is the last winner.
- resp_val = 0 and req_rdy = 0 in every state other than the cases above.
- mem_resp_val outside WAIT is ignored: no strobe and no state change.
- mem_req_rdy outside REQ is ignored.
- Requesters must hold req_val and their request fields stable until req_rdy. The arbiter samples them only in the accept cycle.
- A requester may assert req_val again in the same cycle its resp_val arrives. It is not eligible until the next IDLE cycle.

## Timing
- Reset: state IDLE; ptr = 0, gnt = 0, latched fields = 0. Outputs req_rdy = 0, mem_req_val = 0, mem_req_addr = 0, mem_req_wen = 0, mem_req_wdata = 0, resp_val = 0, grant_sel = 0, busy = 0.
- Reset mid-transaction: abandon the transaction immediately. Any later mem_resp_val is ignored because the FSM is in IDLE.
- Latency, with accept at cycle 0:
  - mem_req_val is high from cycle 1.
  - If mem_req_rdy is high at cycle 1, WAIT is entered at cycle 2.
  - resp_val appears in the same cycle as mem_resp_val.
  - The next accept is possible the cycle after the response.
- Throughput: at most one transaction per 3 + L cycles, where L is the number of memory wait cycles.
- Fairness: with all eight requesters continuously requesting, each is granted once per eight transactions, in order ptr, ptr+1, ….
- Combinational paths:
  - req_rdy depends on req_val and state.
  - resp_val and resp_data depend on mem_resp_val, mem_resp_data and state.
  - There is no path from mem_req_rdy to any output.

## Test plan
- Reset, then req_val = 8'b0000_0100 with addr2 = 0x40 and wen = 0 -> req_rdy = 0x04 at cycle 0; mem_req_val = 1 with addr 0x40 and wen 0 at cycle 1; grant_sel = 2. Memory returns 0xDEAD -> resp_val = 0x04 and resp_data = 0xDEAD in the same cycle.
- req_val = 0xFF held through eight transactions with ptr starting at 0 -> grant order 0,1,2,3,4,5,6,7. The ninth grant is 0.
- ptr = 6 (after granting 5), req_val = 0x41 -> grant 6 first, then 0 (wrap-around).
- Back-pressure: hold mem_req_rdy = 0 for 4 cycles in REQ -> mem_req_val, mem_req_addr and mem_req_wdata stay constant, and req_rdy stays 0 for new requests.
- Write: requester 3, addr 0x10, wdata 0x1234, wen 1 -> mem_req_wen = 1 and mem_req_wdata = 0x1234. The response ack yields resp_val = 0x08.
- Assert reset in WAIT, then pulse mem_resp_val -> resp_val stays 0, busy = 0, and after release the first grant follows priority from 0.
